// File: rtl/arc4_pkg.sv
// Shared types and constants for the RC4 decrypt engine.
package arc4_pkg;

  localparam int S_DEPTH = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_DROP,
    ST_LEN,
    ST_PRGA
  } arc4_state_t;

endpackage

// File: rtl/arc4_key_sel.sv
// Variable-length key byte selector: wrapping key-byte pointer plus byte mux.
module arc4_key_sel
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [8*KEY_BYTES-1:0]           key,
  input  logic [$clog2(KEY_BYTES+1)-1:0]   key_len,
  input  logic                             clear,
  input  logic                             step,
  output byte_t                            key_byte
);

  localparam int LEN_W = $clog2(KEY_BYTES + 1);
  localparam int KP_W  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  logic [KP_W-1:0] kp;
  logic            kp_last;

  // Wrap by comparing kp+1 against key_len, which avoids a modulo divider.
  assign kp_last = (LEN_W'(kp) + LEN_W'(1)) == key_len;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      kp <= '0;
    end else if (step) begin
      kp <= kp_last ? '0 : kp + KP_W'(1);
    end
  end

  // NOTE: every variable in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kp == KP_W'(b)) key_byte = key[8*(KEY_BYTES-1-b) +: 8];
    end
  end

endmodule

// File: rtl/arc4_engine.sv
// RC4 decrypt engine: INIT -> KSA -> optional keystream drop -> LEN -> PRGA over an external S-memory.
module arc4_engine
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int DROP_W    = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  output logic                           rdy,
  input  logic                           abort,
  input  logic [8*KEY_BYTES-1:0]         key,
  input  logic [$clog2(KEY_BYTES+1)-1:0] key_len,
  input  logic [DROP_W-1:0]              drop_n,
  output logic [7:0]                     s_addr,
  output logic [7:0]                     s_wrdata,
  output logic                           s_wren,
  input  logic [7:0]                     s_rddata,
  output logic [7:0]                     ct_addr,
  input  logic [7:0]                     ct_rddata,
  output logic [7:0]                     pt_addr,
  output logic [7:0]                     pt_wrdata,
  output logic                           pt_wren,
  output logic                           done,
  output logic                           err
);

  localparam int    LEN_W    = $clog2(KEY_BYTES + 1);
  localparam byte_t LAST_IDX = byte_t'(S_DEPTH - 1);

  arc4_state_t              state;
  logic [2:0]               ph;
  byte_t                    i_r, j_r, si_r, sj_r, k_r, len_r;
  logic [DROP_W-1:0]        dcnt, drop_r;
  logic [8*KEY_BYTES-1:0]   key_r;
  logic [LEN_W-1:0]         key_len_r;
  byte_t                    key_byte, j_step;
  logic                     bad_len;

  assign bad_len = (key_len == '0) || (key_len > LEN_W'(KEY_BYTES));

  arc4_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .clk      (clk),
    .rst      (rst),
    .key      (key_r),
    .key_len  (key_len_r),
    .clear    (state == ST_IDLE),
    .step     (state == ST_KSA && ph == 3'd3),
    .key_byte (key_byte)
  );

  // S[i] arrives this cycle; the key byte only participates during KSA.
  assign j_step = j_r + s_rddata + ((state == ST_KSA) ? key_byte : 8'd0);

  // Memory ports are decoded combinationally: j and the swap data depend on read data returned in the same cycle.
  always_comb begin
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    unique case (state)
      ST_INIT: begin
        s_addr   = i_r;
        s_wrdata = i_r;
        s_wren   = 1'b1;
      end
      ST_KSA, ST_DROP, ST_PRGA: begin
        unique case (ph)
          3'd0: s_addr = i_r;
          3'd1: s_addr = j_step;
          3'd2: begin
            s_addr   = i_r;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
          end
          3'd3: begin
            s_addr   = j_r;
            s_wrdata = si_r;
            s_wren   = 1'b1;
          end
          3'd4: begin
            s_addr  = si_r + sj_r;
            ct_addr = k_r;
          end
          3'd5: begin
            pt_addr   = k_r;
            pt_wrdata = ct_rddata ^ s_rddata;
            pt_wren   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_LEN: begin
        if (ph != 3'd0) begin
          pt_wrdata = ct_rddata;
          pt_wren   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ph        <= '0;
      i_r       <= '0;
      j_r       <= '0;
      si_r      <= '0;
      sj_r      <= '0;
      k_r       <= '0;
      len_r     <= '0;
      dcnt      <= '0;
      drop_r    <= '0;
      key_r     <= '0;
      key_len_r <= '0;
      rdy       <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        ph    <= '0;
        rdy   <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (en) begin
              if (bad_len) begin
                err <= 1'b1;
              end else begin
                key_r     <= key;
                key_len_r <= key_len;
                drop_r    <= drop_n;
                state     <= ST_INIT;
                rdy       <= 1'b0;
                ph        <= '0;
                i_r       <= '0;
                j_r       <= '0;
              end
            end
          end
          ST_INIT: begin
            i_r <= i_r + 8'd1;
            if (i_r == LAST_IDX) state <= ST_KSA;
          end
          ST_KSA, ST_DROP, ST_PRGA: begin
            ph <= ph + 3'd1;
            if (ph == 3'd1) begin
              j_r  <= j_step;
              si_r <= s_rddata;
            end
            if (ph == 3'd2) sj_r <= s_rddata;
            if (ph == 3'd3 && state == ST_KSA) begin
              ph  <= '0;
              i_r <= i_r + 8'd1;
              if (i_r == LAST_IDX) begin
                j_r <= '0;
                if (drop_r != '0) begin
                  state <= ST_DROP;
                  i_r   <= 8'd1;
                  dcnt  <= drop_r;
                end else begin
                  state <= ST_LEN;
                  i_r   <= '0;
                end
              end
            end
            if (ph == 3'd3 && state == ST_DROP) begin
              ph   <= '0;
              dcnt <= dcnt - DROP_W'(1);
              // i is left as-is on exit; the LEN->PRGA step does the next increment.
              if (dcnt == DROP_W'(1)) state <= ST_LEN;
              else                    i_r   <= i_r + 8'd1;
            end
            if (ph == 3'd5) begin
              ph <= '0;
              if (k_r == len_r) begin
                state <= ST_IDLE;
                done  <= 1'b1;
                rdy   <= 1'b1;
              end else begin
                k_r <= k_r + 8'd1;
                i_r <= i_r + 8'd1;
              end
            end
          end
          ST_LEN: begin
            if (ph == 3'd0) begin
              ph <= 3'd1;
            end else begin
              ph    <= '0;
              len_r <= ct_rddata;
              if (ct_rddata == 8'd0) begin
                state <= ST_IDLE;
                done  <= 1'b1;
                rdy   <= 1'b1;
              end else begin
                state <= ST_PRGA;
                k_r   <= 8'd1;
                i_r   <= i_r + 8'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arc4_engine.sv
// Directed-vector bench for arc4_engine with behavioural S/CT/PT memories and a reference RC4 model.
module tb_arc4_engine;

  localparam int KB = 8;
  localparam int DW = 10;

  logic        clk = 1'b0;
  logic        rst, en, abort;
  logic [63:0] key;
  logic [3:0]  key_len;
  logic [9:0]  drop_n;
  logic        rdy, done, err;
  logic [7:0]  s_addr, s_wrdata, s_rddata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
  logic        s_wren, pt_wren;

  logic [7:0]  s_mem  [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  pt_mem [256];
  logic [7:0]  exp_pt [256];
  logic [7:0]  ks     [256];

  int checks = 0, failures = 0;
  int pt_writes = 0, act = 0, idle_wr = 0, done_cnt = 0;

  arc4_engine #(.KEY_BYTES(KB), .DROP_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .abort(abort),
    .key(key), .key_len(key_len), .drop_n(drop_n),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (pt_wren) begin
      pt_mem[pt_addr] <= pt_wrdata;
      pt_writes <= pt_writes + 1;
    end
  end

  always @(negedge clk) begin
    if (rdy && (s_wren || pt_wren)) idle_wr <= idle_wr + 1;
    if (s_wren || pt_wren || ct_addr != 8'd0 || s_addr != 8'd0) act <= act + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Textbook RC4 with drop: ks[0..n-1] = keystream bytes drop..drop+n-1.
  task automatic model_ks(input logic [63:0] k, input int kl, input int drop, input int n);
    logic [7:0] s [256];
    logic [7:0] t;
    int i, j;
    for (int a = 0; a < 256; a++) s[a] = a[7:0];
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + int'(s[a]) + int'(k[63-8*(a%kl) -: 8])) % 256;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int a = 0; a < drop + n; a++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (a >= drop) ks[a-drop] = s[(int'(s[i]) + int'(s[j])) % 256];
    end
  endtask

  // Byte 1 of the message is the most significant byte of the n-byte literal.
  task automatic load_vec(input int n, input logic [127:0] ct_v, input logic [127:0] pt_v);
    ct_mem[0] = n[7:0];
    exp_pt[0] = n[7:0];
    for (int m = 1; m <= n; m++) begin
      ct_mem[m] = ct_v[8*(n-m) +: 8];
      exp_pt[m] = pt_v[8*(n-m) +: 8];
    end
  endtask

  task automatic load_model(input logic [63:0] k, input int kl, input int dn, input int n);
    model_ks(k, kl, dn, n);
    ct_mem[0] = n[7:0];
    exp_pt[0] = n[7:0];
    for (int m = 1; m <= n; m++) begin
      ct_mem[m] = 8'($urandom);
      exp_pt[m] = ct_mem[m] ^ ks[m-1];
    end
  endtask

  task automatic check_pt(input string tag, input int n);
    for (int m = 0; m <= n; m++) check($sformatf("%s_pt%0d", tag, m), pt_mem[m], exp_pt[m]);
  endtask

  task automatic run(input string tag, input logic [63:0] k, input logic [3:0] kl,
                     input logic [9:0] dn, input int n, input bit hold);
    int lat, pw0, exp_lat;
    exp_lat = 1283 + 4*int'(dn) + 6*n;
    lat = -1;
    pw0 = pt_writes;
    @(negedge clk);
    key = k; key_len = kl; drop_n = dn; en = 1'b1;
    for (int c = 1; c <= exp_lat + 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, "_rdy_low"}, rdy, 1'b0);
        if (hold) begin
          key = ~k; key_len = 4'd0; drop_n = ~dn;
        end else begin
          en = 1'b0;
        end
      end
      if (done) begin
        lat = c;
        en = 1'b0;
        break;
      end
    end
    en = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rdy_at_done"}, rdy, 1'b1);
    check({tag, "_pt_writes"}, pt_writes - pw0, n + 1);
    check_pt(tag, n);
  endtask

  task automatic kick(input logic [63:0] k, input logic [3:0] kl, input logic [9:0] dn);
    @(negedge clk);
    key = k; key_len = kl; drop_n = dn; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic quiet_after(input string tag);
    int a0, d0;
    check({tag, "_rdy"}, rdy, 1'b1);
    check({tag, "_s_wren"}, s_wren, 1'b0);
    check({tag, "_pt_wren"}, pt_wren, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    a0 = act; d0 = done_cnt;
    repeat (8) @(negedge clk);
    check({tag, "_no_activity"}, act - a0, 0);
    check({tag, "_no_done"}, done_cnt - d0, 0);
  endtask

  localparam logic [63:0] KEY_KEY  = 64'h4B6579_0000000000;
  localparam logic [63:0] KEY_WIKI = 64'h57696B69_00000000;

  initial begin
    rst = 1'b1; en = 1'b0; abort = 1'b0;
    key = '0; key_len = '0; drop_n = '0;
    repeat (3) @(negedge clk);
    check("rst_rdy", rdy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_wren", {s_wren, pt_wren}, 2'b00);
    check("rst_addr", {s_addr, ct_addr, pt_addr}, 24'h0);
    check("rst_wrdata", {s_wrdata, pt_wrdata}, 16'h0);
    rst = 1'b0;

    load_vec(9, 72'hBBF316E8D940AF0AD3, 72'h506C61696E74657874);
    run("key_plaintext", KEY_KEY, 4'd3, 10'd0, 9, 1'b0);

    load_vec(5, 40'h1021BF0420, 40'h7065646961);
    run("wiki_pedia", KEY_WIKI, 4'd4, 10'd0, 5, 1'b0);

    for (int t = 0; t < 2; t++) begin
      int a0;
      string tg;
      tg = (t == 0) ? "err_len0" : "err_len9";
      a0 = act;
      @(negedge clk);
      key = KEY_KEY; key_len = (t == 0) ? 4'd0 : 4'd9; drop_n = 10'd0; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check({tg, "_err"}, err, 1'b1);
      check({tg, "_rdy"}, rdy, 1'b1);
      @(negedge clk);
      check({tg, "_err_pulse"}, err, 1'b0);
      repeat (6) @(negedge clk);
      check({tg, "_no_activity"}, act - a0, 0);
      check({tg, "_rdy_held"}, rdy, 1'b1);
    end

    load_vec(0, 0, 0);
    run("len0", KEY_KEY, 4'd3, 10'd0, 0, 1'b0);
    run("len0_drop3", KEY_KEY, 4'd3, 10'd3, 0, 1'b0);

    // Zero ciphertext exposes raw keystream bytes 3..8 of key "Key".
    load_vec(6, 48'h0, 48'h81B734CA72A7);
    run("drop3", KEY_KEY, 4'd3, 10'd3, 6, 1'b0);

    load_vec(9, 72'hBBF316E8D940AF0AD3, 72'h506C61696E74657874);
    kick(KEY_KEY, 4'd3, 10'd0);
    repeat (400) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    quiet_after("abort_ksa");
    run("after_abort_ksa", KEY_KEY, 4'd3, 10'd0, 9, 1'b0);

    kick(KEY_KEY, 4'd3, 10'd0);
    repeat (1283 + 20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    quiet_after("abort_prga");
    run("after_abort_prga", KEY_KEY, 4'd3, 10'd0, 9, 1'b0);

    load_model(64'h0A1B2C3D4E000000, 5, 7, 20);
    run("en_held", 64'h0A1B2C3D4E000000, 4'd5, 10'd7, 20, 1'b1);

    load_vec(9, 72'hBBF316E8D940AF0AD3, 72'h506C61696E74657874);
    kick(KEY_KEY, 4'd3, 10'd0);
    repeat (1283 + 25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rdy", rdy, 1'b1);
    check("midrst_done_err", {done, err}, 2'b00);
    check("midrst_wren", {s_wren, pt_wren}, 2'b00);
    check("midrst_addr", {s_addr, ct_addr, pt_addr}, 24'h0);
    check("midrst_wrdata", {s_wrdata, pt_wrdata}, 16'h0);
    rst = 1'b0;
    run("after_midrst", KEY_KEY, 4'd3, 10'd0, 9, 1'b0);

    load_model(64'h0123456789ABCDEF, 8, 0, 255);
    run("len255", 64'h0123456789ABCDEF, 4'd8, 10'd0, 255, 1'b0);

    check("no_wren_while_idle", idle_wr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
